// File: rtl/riscv_debug_pkg.sv
// Shared encodings and transaction types for the RISC-V debug instruction path,
// used by both the host-side initiator and the pipeline-side debug decoder.
package riscv_debug_pkg;

    typedef enum logic [1:0] {
        DBG_OP_READ  = 2'd0,
        DBG_OP_WRITE = 2'd1
    } debug_op_e;

    typedef enum logic [1:0] {
        STATUS_OK         = 2'd0,
        STATUS_NOT_HALTED = 2'd1,
        STATUS_BAD_ADDR   = 2'd2,
        STATUS_TIMEOUT    = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } initiator_state_e;

    localparam int GPR_SEL_BIT = 12;

    // Request payload as captured from the host (the valid bit is not stored).
    typedef struct packed {
        logic        write;
        logic        is_gpr;
        logic [11:0] address;
        logic [31:0] write_data;
    } dbg_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        status_e     status;
    } dbg_resp_t;

    typedef struct packed {
        logic        valid;
        debug_op_e   debug_op;
        logic [15:0] data;
    } instr_debug_t;

    function automatic logic [15:0] pack_debug_data(input logic is_gpr, input logic [11:0] address);
        logic [15:0] d;
        d = {4'b0000, address};
        d[GPR_SEL_BIT] = is_gpr;
        return d;
    endfunction

    // Only x0..x31 exist; any GPR number using bits above [4:0] is rejected.
    function automatic logic is_bad_address(input logic is_gpr, input logic [11:0] address);
        return is_gpr && (address[11:5] != 7'd0);
    endfunction

endpackage

// File: rtl/riscv_i32_debug_initiator.sv
// Debug-host-side initiator: accepts one GPR/CSR access at a time, issues it to the
// pipeline's debug port with a valid/ack handshake, and returns data plus status.
module riscv_i32_debug_initiator
    import riscv_debug_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_halted,
    input  logic        dbg_req__valid,
    input  logic        dbg_req__write,
    input  logic        dbg_req__is_gpr,
    input  logic [11:0] dbg_req__address,
    input  logic [31:0] dbg_req__write_data,
    output logic        dbg_req_ready,
    output logic        dbg_resp__valid,
    output logic [31:0] dbg_resp__data,
    output logic [1:0]  dbg_resp__status,
    input  logic        dbg_resp_ready,
    output logic        instruction__debug__valid,
    output logic [1:0]  instruction__debug__debug_op,
    output logic [15:0] instruction__debug__data,
    output logic [31:0] instruction__data,
    input  logic        pipeline_ack,
    input  logic        pipeline_resp__valid,
    input  logic [31:0] pipeline_resp__data
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    initiator_state_e state;
    dbg_req_t         req_q;
    dbg_resp_t        resp_q;
    instr_debug_t     instr_q;
    logic [7:0]       timer;

    // Completion in the same cycle as expiry takes priority over the timeout.
    logic completing;
    always_comb begin
        completing = 1'b0;
        if (state == ST_ISSUE)
            completing = pipeline_ack && pipeline_resp__valid;
        else if (state == ST_WAIT)
            completing = pipeline_resp__valid;
    end

    // NOTE: all state is updated with non-blocking assignments so every branch sees
    // the pre-edge values; reset is synchronous and clears the captured request too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            resp_q  <= '0;
            instr_q <= '0;
            timer   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbg_req__valid) begin
                        req_q <= '{write:      dbg_req__write,
                                   is_gpr:     dbg_req__is_gpr,
                                   address:    dbg_req__address,
                                   write_data: dbg_req__write_data};
                        if (!core_halted) begin
                            resp_q <= '{valid: 1'b1, data: 32'd0, status: STATUS_NOT_HALTED};
                            state  <= ST_RESPOND;
                        end else if (is_bad_address(dbg_req__is_gpr, dbg_req__address)) begin
                            resp_q <= '{valid: 1'b1, data: 32'd0, status: STATUS_BAD_ADDR};
                            state  <= ST_RESPOND;
                        end else begin
                            instr_q <= '{valid:    1'b1,
                                         debug_op: dbg_req__write ? DBG_OP_WRITE : DBG_OP_READ,
                                         data:     pack_debug_data(dbg_req__is_gpr, dbg_req__address)};
                            timer   <= '0;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE, ST_WAIT: begin
                    if (completing) begin
                        resp_q <= '{valid:  1'b1,
                                    data:   req_q.write ? 32'd0 : pipeline_resp__data,
                                    status: STATUS_OK};
                        instr_q.valid <= 1'b0;
                        state         <= ST_RESPOND;
                    end else if (timer == TIMER_LAST) begin
                        resp_q        <= '{valid: 1'b1, data: 32'd0, status: STATUS_TIMEOUT};
                        instr_q.valid <= 1'b0;
                        state         <= ST_RESPOND;
                    end else begin
                        timer <= timer + 8'd1;
                        if (state == ST_ISSUE && pipeline_ack) begin
                            instr_q.valid <= 1'b0;
                            state         <= ST_WAIT;
                        end
                    end
                end

                ST_RESPOND: begin
                    if (dbg_resp_ready) begin
                        resp_q <= '0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_req_ready                = (state == ST_IDLE);
    assign dbg_resp__valid              = resp_q.valid;
    assign dbg_resp__data               = resp_q.data;
    assign dbg_resp__status             = resp_q.status;
    assign instruction__debug__valid    = instr_q.valid;
    assign instruction__debug__debug_op = instr_q.debug_op;
    assign instruction__debug__data     = instr_q.data;
    assign instruction__data            = req_q.write ? req_q.write_data : 32'd0;

endmodule
